// File: rtl/period_meter_pkg.sv
// Shared timer-family definitions: state encodings and default widths.
// Imported by the period meter and its counter.
package period_meter_pkg;

   localparam int CNT_BITS = 6;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_ARMED = ST_ARMED,
      S_RUN   = ST_RUN
   } pm_state_t;

endpackage

// File: rtl/period_meter_if.sv
// Strobe-in / measurement-out bundle of the period meter.
// master drives tick, en and expect_n; slave is the meter.
interface period_meter_if
   import period_meter_pkg::*;
#(
   parameter int W = CNT_BITS
);

   logic         en;
   logic         tick;
   logic [W-1:0] expect_n;
   logic [W-1:0] period;
   logic         valid;
   logic         match;
   logic         overflow;

   modport master (
      output en, tick, expect_n,
      input  period, valid, match, overflow
   );

   modport slave (
      input  en, tick, expect_n,
      output period, valid, match, overflow
   );

endinterface

// File: rtl/period_cnt.sv
// Interval counter: clear, load-1, increment, with an all-ones flag.
// clr has priority over load1, load1 over inc.
module period_cnt
   import period_meter_pkg::*;
#(
   parameter int W = CNT_BITS
) (
   input  logic         clk,
   input  logic         r_n,
   input  logic         clr,
   input  logic         load1,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         cnt <= '0;
      end else begin
         unique case (1'b1)
            clr:     cnt <= '0;
            load1:   cnt <= ONE;
            inc:     cnt <= cnt + ONE;
            default: cnt <= cnt;
         endcase
      end
   end

   assign at_max = &cnt;

endmodule

// File: rtl/period_meter.sv
// Measures cycles between tick strobes, compares to expect_n,
// and flags a lost tick when the interval saturates the counter.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int counter_bits = CNT_BITS
) (
   input  logic           clk,
   input  logic           r_n,
   period_meter_if.slave  bus
);

   pm_state_t                state;
   logic [counter_bits-1:0]  cnt;
   logic                     at_max;
   logic                     clr;
   logic                     load1;
   logic                     inc;
   logic [counter_bits-1:0]  period_q;
   logic                     valid_q;
   logic                     match_q;
   logic                     ovf_q;
   logic                     in_run;
   logic                     in_arm;

   assign in_run = (state == S_RUN);
   assign in_arm = (state == S_ARMED);

   // counter control mirrors the FSM transitions below
   assign clr   = !bus.en
                | (state == S_IDLE)
                | (in_run & !bus.tick & at_max);
   assign load1 = bus.en & bus.tick & (in_arm | in_run);
   assign inc   = bus.en & in_run & !bus.tick & !at_max;

   period_cnt #(
      .W (counter_bits)
   ) u_cnt (
      .clk    (clk),
      .r_n    (r_n),
      .clr    (clr),
      .load1  (load1),
      .inc    (inc),
      .cnt    (cnt),
      .at_max (at_max)
   );

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state    <= S_IDLE;
         period_q <= '0;
         valid_q  <= 1'b0;
         match_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!bus.en) begin
            state <= S_IDLE;
            ovf_q <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  state <= S_ARMED;
               end
               S_ARMED: begin
                  if (bus.tick) state <= S_RUN;
               end
               S_RUN: begin
                  if (bus.tick) begin
                     period_q <= cnt;
                     match_q  <= (cnt == bus.expect_n)
                               && (bus.expect_n != '0);
                     valid_q  <= 1'b1;
                  end else if (at_max) begin
                     ovf_q <= 1'b1;
                     state <= S_ARMED;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.period   = period_q;
   assign bus.valid    = valid_q;
   assign bus.match    = match_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with hand-computed expectations.
// Outputs are sampled 1 time unit after each rising edge.
module tb_period_meter;
   import period_meter_pkg::*;

   logic clk;
   logic r_n;
   int   checks;
   int   errors;

   period_meter_if #(.W(6)) bus_if ();

   period_meter #(
      .counter_bits (6)
   ) dut (
      .clk (clk),
      .r_n (r_n),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic t);
      bus_if.tick = t;
      @(posedge clk);
      #1;
      bus_if.tick = 1'b0;
   endtask

   task automatic chk_meas(input string tag, input int p,
                           input int m, input int o);
      chk({tag, "_valid"}, int'(bus_if.valid), 1);
      chk({tag, "_period"}, int'(bus_if.period), p);
      chk({tag, "_match"}, int'(bus_if.match), m);
      chk({tag, "_ovf"}, int'(bus_if.overflow), o);
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      r_n             = 1'b0;
      bus_if.en       = 1'b0;
      bus_if.tick     = 1'b0;
      bus_if.expect_n = 6'd5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_period", int'(bus_if.period), 0);
      chk("rst_valid", int'(bus_if.valid), 0);
      chk("rst_match", int'(bus_if.match), 0);
      chk("rst_ovf", int'(bus_if.overflow), 0);
      r_n = 1'b1;

      // period 5, expect 5
      bus_if.en = 1'b1;
      cyc(1'b1);
      chk("rise_tick_ign", int'(bus_if.valid), 0);
      cyc(1'b1);
      chk("arm_novalid", int'(bus_if.valid), 0);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) begin
            cyc(1'b0);
            chk("p5_gap", int'(bus_if.valid), 0);
         end
         cyc(1'b1);
         chk_meas("p5_m", 5, 1, 0);
      end

      // same stream, expect 4
      bus_if.expect_n = 6'd4;
      for (int k = 0; k < 2; k++) begin
         repeat (4) cyc(1'b0);
         cyc(1'b1);
         chk_meas("p5_e4", 5, 0, 0);
      end

      // back-to-back ticks
      bus_if.expect_n = 6'd1;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1);
         chk_meas("p1", 1, 1, 0);
      end
      cyc(1'b0);
      chk("p1_drop", int'(bus_if.valid), 0);
      cyc(1'b1);
      chk_meas("p2", 2, 0, 0);

      // lost tick: overflow in the 64th cycle after the tick
      for (int k = 0; k < 62; k++) cyc(1'b0);
      chk("ovf_pre", int'(bus_if.overflow), 0);
      cyc(1'b0);
      chk("ovf_set", int'(bus_if.overflow), 1);
      chk("ovf_novalid", int'(bus_if.valid), 0);
      cyc(1'b0);
      chk("ovf_sticky", int'(bus_if.overflow), 1);

      // clear via en, then a tick exactly at +63
      bus_if.en = 1'b0;
      cyc(1'b0);
      chk("en_clr_ovf", int'(bus_if.overflow), 0);
      bus_if.en       = 1'b1;
      bus_if.expect_n = 6'd63;
      cyc(1'b0);
      cyc(1'b1);
      for (int k = 0; k < 62; k++) cyc(1'b0);
      cyc(1'b1);
      chk_meas("p63", 63, 1, 0);

      // async reset mid-RUN
      cyc(1'b0);
      cyc(1'b0);
      #2 r_n = 1'b0;
      #1;
      chk("arst_period", int'(bus_if.period), 0);
      chk("arst_match", int'(bus_if.match), 0);
      chk("arst_ovf", int'(bus_if.overflow), 0);
      #1 r_n = 1'b1;
      bus_if.expect_n = 6'd3;
      cyc(1'b0);
      cyc(1'b1);
      chk("arst_arm", int'(bus_if.valid), 0);
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b1);
      chk_meas("arst_p3", 3, 1, 0);

      // en dropped with a tick while overflow is set
      for (int k = 0; k < 63; k++) cyc(1'b0);
      chk("ovf2_set", int'(bus_if.overflow), 1);
      cyc(1'b1);
      cyc(1'b0);
      bus_if.en = 1'b0;
      cyc(1'b1);
      chk("entick_valid", int'(bus_if.valid), 0);
      chk("entick_ovf", int'(bus_if.overflow), 0);
      chk("entick_period", int'(bus_if.period), 3);
      chk("entick_match", int'(bus_if.match), 1);
      bus_if.en       = 1'b1;
      bus_if.expect_n = 6'd0;
      cyc(1'b1);
      chk("reen_rise", int'(bus_if.valid), 0);
      cyc(1'b1);
      chk("reen_arm", int'(bus_if.valid), 0);
      cyc(1'b0);
      cyc(1'b1);
      chk_meas("reen_p2_e0", 2, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
